// File: rtl/sprite_motion_if.sv
// Sprite motion port bundle: frame sync and active-low keys in, registered
// sprite position and status out.
interface sprite_motion_if;
  logic       vert_sync;
  logic       k0;
  logic       k1;
  logic       k2;
  logic       k3;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic       frame_tick;
  logic       moving;

  modport master (
    output vert_sync, k0, k1, k2, k3,
    input  sprite_x, sprite_y, frame_tick, moving
  );

  modport slave (
    input  vert_sync, k0, k1, k2, k3,
    output sprite_x, sprite_y, frame_tick, moving
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite motion controller: synchronizes vert_sync and keys,
// debounces keys per frame and commits one bounded, accelerating move per frame.
module sprite_motion_ctrl #(
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 360,
  parameter int X_MIN       = 16,
  parameter int X_MAX       = 624,
  parameter int Y_MIN       = 240,
  parameter int Y_MAX       = 464,
  parameter int HOLD_FRAMES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  sprite_motion_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CALC,
    S_COMMIT
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_INC,
    DIR_DEC
  } dir_e;

  localparam logic [9:0]  X_INIT_P = 10'(X_INIT);
  localparam logic [9:0]  Y_INIT_P = 10'(Y_INIT);
  localparam logic [10:0] X_MIN_P  = 11'(X_MIN);
  localparam logic [10:0] X_MAX_P  = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_P  = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_P  = 11'(Y_MAX);
  localparam logic [6:0]  HOLD_1_P = 7'(HOLD_FRAMES);
  localparam logic [6:0]  HOLD_2_P = 7'(2 * HOLD_FRAMES);

  // Step size grows with the number of consecutive frames held on an axis.
  function automatic logic [10:0] step_of(input logic [5:0] hold);
    logic [10:0] step;
    if ({1'b0, hold} < HOLD_1_P)      step = 11'd1;
    else if ({1'b0, hold} < HOLD_2_P) step = 11'd2;
    else                              step = 11'd4;
    return step;
  endfunction

  // Move one axis and clamp into [lo, hi]; the final clamp also repairs a
  // position that starts out of range, even with no direction.
  function automatic logic [9:0] next_pos(input logic [9:0]  pos,
                                          input dir_e        dir,
                                          input logic [10:0] step,
                                          input logic [10:0] lo,
                                          input logic [10:0] hi);
    logic [10:0] p;
    logic [10:0] cand;
    logic [9:0]  result;
    p = {1'b0, pos};
    case (dir)
      DIR_INC: cand = p + step;
      DIR_DEC: cand = (p < lo + step) ? lo : p - step;
      default: cand = p;
    endcase
    if (cand > hi)      result = hi[9:0];
    else if (cand < lo) result = lo[9:0];
    else                result = cand[9:0];
    return result;
  endfunction

  function automatic logic [5:0] next_hold(input logic [5:0] hold,
                                           input dir_e       dir,
                                           input dir_e       prev);
    logic [5:0] result;
    if (dir == DIR_NONE)  result = 6'd0;
    else if (dir != prev) result = 6'd1;
    else if (hold == '1)  result = hold;
    else                  result = hold + 6'd1;
    return result;
  endfunction

  logic [1:0]      vs_sync;
  logic            vs_prev;
  logic            frame_tick_q;
  logic [3:0]      key_meta;
  logic [3:0]      key_sync;
  logic [3:0][1:0] key_hist;
  logic [3:0]      key_pressed;

  state_e     state_q;
  state_e     state_d;
  dir_e       dir_x_res;
  dir_e       dir_y_res;
  dir_e       dir_x_q;
  dir_e       dir_y_q;
  dir_e       prev_dir_x_q;
  dir_e       prev_dir_y_q;
  logic [9:0] cand_x_q;
  logic [9:0] cand_y_q;
  logic [9:0] pos_x_q;
  logic [9:0] pos_y_q;
  logic [5:0] hold_x_q;
  logic [5:0] hold_y_q;
  logic       moving_q;

  // NOTE: sync flops reset to 1 so a vert_sync already high at reset release
  // yields no tick and every key reads as released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sync      <= 2'b11;
      vs_prev      <= 1'b1;
      frame_tick_q <= 1'b0;
      key_meta     <= '1;
      key_sync     <= '1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value,
      // which is what makes this a real shift chain.
      vs_sync      <= {vs_sync[0], bus.vert_sync};
      vs_prev      <= vs_sync[1];
      frame_tick_q <= vs_sync[1] & ~vs_prev;
      key_meta     <= {bus.k3, bus.k2, bus.k1, bus.k0};
      key_sync     <= key_meta;
    end
  end

  // Per-key two-frame history; a key is pressed only after two low ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_hist <= '1;
    end else if (frame_tick_q) begin
      for (int i = 0; i < 4; i++) begin
        key_hist[i] <= {key_hist[i][0], key_sync[i]};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      key_pressed[i] = (key_hist[i] == 2'b00);
    end
  end

  // Right beats left, down beats up.
  always_comb begin
    dir_x_res = DIR_NONE;
    dir_y_res = DIR_NONE;
    if (key_pressed[0])      dir_x_res = DIR_INC;
    else if (key_pressed[1]) dir_x_res = DIR_DEC;
    if (key_pressed[2])      dir_y_res = DIR_INC;
    else if (key_pressed[3]) dir_y_res = DIR_DEC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Ticks arriving outside IDLE are ignored.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d
    // unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_tick_q) state_d = S_SAMPLE;
      S_SAMPLE: state_d = S_CALC;
      S_CALC:   state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_x_q      <= DIR_NONE;
      dir_y_q      <= DIR_NONE;
      prev_dir_x_q <= DIR_NONE;
      prev_dir_y_q <= DIR_NONE;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      pos_x_q      <= X_INIT_P;
      pos_y_q      <= Y_INIT_P;
      hold_x_q     <= '0;
      hold_y_q     <= '0;
      moving_q     <= 1'b0;
    end else begin
      case (state_q)
        S_SAMPLE: begin
          dir_x_q <= dir_x_res;
          dir_y_q <= dir_y_res;
        end
        S_CALC: begin
          cand_x_q <= next_pos(pos_x_q, dir_x_q, step_of(hold_x_q), X_MIN_P, X_MAX_P);
          cand_y_q <= next_pos(pos_y_q, dir_y_q, step_of(hold_y_q), Y_MIN_P, Y_MAX_P);
        end
        S_COMMIT: begin
          pos_x_q      <= cand_x_q;
          pos_y_q      <= cand_y_q;
          moving_q     <= (cand_x_q != pos_x_q) || (cand_y_q != pos_y_q);
          hold_x_q     <= next_hold(hold_x_q, dir_x_q, prev_dir_x_q);
          hold_y_q     <= next_hold(hold_y_q, dir_y_q, prev_dir_y_q);
          prev_dir_x_q <= dir_x_q;
          prev_dir_y_q <= dir_y_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.sprite_x   = pos_x_q;
  assign bus.sprite_y   = pos_y_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.moving     = moving_q;

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Frame-synchronous motion controller for a single sprite in the VGA controller. It runs on the pixel clock and detects each rising edge of `vert_sync`. It debounces the four active-low push keys and then, once per frame, computes a new bounded sprite position with hold-to-accelerate stepping. Its `sprite_x`/`sprite_y` outputs are the registered position that the sprite-drawing logic compares against `pixel_column`/`pixel_row`. Positions change only once per frame, a few cycles after the `vert_sync` edge, never mid-line.

## Interface
- `X_INIT`, 320: reset x position (pixels).
- `Y_INIT`, 360: reset y position.
- `X_MIN`, 16: lowest legal x.
- `X_MAX`, 624: highest legal x (640 − 16 sprite size).
- `Y_MIN`, 240: lowest legal y.
- `Y_MAX`, 464: highest legal y (480 − 16).
- `HOLD_FRAMES`, 16: frames of continuous motion per acceleration stage.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: pixel clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `vert_sync`  in  1: frame sync from the VGA timing block; asynchronous to this block's logic and synchronized internally.
- `k0`  in  1: right key, active-low.
- `k1`  in  1: left key, active-low.
- `k2`  in  1: down key, active-low.
- `k3`  in  1: up key, active-low.
- `sprite_x`  out  10: current x position, registered.
- `sprite_y`  out  10: current y position, registered.
- `frame_tick`  out  1: one-cycle pulse per detected `vert_sync` rising edge.
- `moving`  out  1: high if the last commit changed either coordinate.

## Operation
- Sync: `vert_sync` and `k0`..`k3` each pass through a 2-flop synchronizer.
- Edge detect: `frame_tick` is high for the cycle in which the synchronized `vert_sync` is 1 and its previous value was 0.
- Debounce: on each `frame_tick`, every synchronized key is shifted into a 2-bit per-key history. A key counts as pressed only when both history bits are 0, i.e. it was low on 2 consecutive frame ticks. One frame low is ignored.
- FSM states: IDLE, SAMPLE, CALC, COMMIT.
  - IDLE → SAMPLE on `frame_tick`.
  - SAMPLE: latch the debounced keys. Resolve direction per axis:
    - x: k0 beats k1, so both pressed means right.
    - y: k2 beats k3, so both pressed means down.
    - If neither key on an axis is pressed, that axis direction is none.
    - Go to CALC.
  - CALC: compute candidate x/y with 11-bit arithmetic, then clamp.
    - Increasing: if `pos + step > MAX`, result is MAX, else `pos + step`.
    - Decreasing: if `pos < MIN + step`, result is MIN, else `pos − step`. The position never wraps below 0.
    - Direction none leaves the position unchanged.
    - Go to COMMIT.
  - COMMIT: write `sprite_x`, `sprite_y` and `moving`; update the hold counters; go to IDLE.
- A `frame_tick` seen outside IDLE is dropped.
- Hold counters: one per axis, 6 bits, saturating.
  - Count +1 each commit in which that axis keeps the same nonzero direction as the previous commit.
  - Set to 0 on direction none.
  - Set to 1 on a direction change.
  - A clamped move still counts as movement.
- Step size from the axis counter:
  - count < HOLD_FRAMES: step 1.
  - HOLD_FRAMES ≤ count < 2·HOLD_FRAMES: step 2.
  - count ≥ 2·HOLD_FRAMES: step 4.
- A position outside [MIN, MAX], which only happens through mis-set parameters, is clamped into range on the next commit, including when direction is none.
- Reset, asynchronous: takes effect immediately, including mid-FSM with no partial commit.
  - `sprite_x` = X_INIT, `sprite_y` = Y_INIT.
  - `frame_tick` = 0, `moving` = 0.
  - State IDLE.
  - Sync flops = 1, so a `vert_sync` already high at reset release produces no tick and keys read as released.
  - Key histories = 11, hold counters = 0.

## Timing
- Raw `vert_sync` rise sampled at edge E: `frame_tick` is high in cycle E+2 (2 sync stages, then the edge compare).
- With `frame_tick` high in cycle T, the FSM is in SAMPLE at T+1, CALC at T+2 and COMMIT at T+3. New `sprite_x`/`sprite_y`/`moving` are visible from T+4.
- Outputs hold constant for the rest of the frame.
- A key must be low at 2 consecutive ticks before the position moves. The first move commits in the frame of the second such tick.
- Throughput: one update per frame, minimum 4 cycles between ticks.

## Test plan
- Reset with no keys, then 3 `vert_sync` pulses → `sprite_x`=320, `sprite_y`=360, `moving`=0, and exactly 3 one-cycle `frame_tick` pulses.
- Hold k0 low for 5 frames → frame 1 no move; frames 2–5 step x 321..324; `moving`=1; each update lands 4 clk after its `frame_tick`.
- k0 and k1 both low, plus k2 and k3 both low, for 3 frames → x and y each increase by 1 per frame from frame 2 (right and down win).
- Hold k1 from x=17 → x goes 16 and stays 16; `moving`=0 after the clamp. Hold k3 from y=241 → 240. Hold k0 from x=623 → 624.
- Hold k0 for 40 frames → step 1 until the hold count reaches 16, then 2, then 4 from count 32. Release one frame then press again → step back to 1.
- Assert `rst_n` in the CALC cycle while k0 is held → outputs return to 320/360 at once with no commit; one-frame glitch pulses on k2 never move y.
